sseg_writeback_display: RTL and testbench

SSEG_WRITEBACK_DISPLAY -- requirements
Module: sseg_writeback_display

---
 rtl/sseg_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 53 +++++
 rtl/sseg_writeback_display.sv | 143 ++++++++++++++
 tb/tb_sseg_writeback_display.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared glyph table, FSM state type and blank constant for the writeback display
package sseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a patterns, entry 15 first so HEX_GLYPH[n] is the glyph for n
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        return HEX_GLYPH[n];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - power-of-two synchronous FIFO buffering writeback words
module wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sseg_writeback_display.sv
// rtl/sseg_writeback_display.sv - buffered writeback word shown on a scanned seven-segment display
// Optional leading-zero blanking: define SSEG_BLANK_LEAD_EN.
module sseg_writeback_display
    import sseg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SCAN_DIV    = 1000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic                          overflow,
    output logic [NUM_DIGITS-1:0]         sseg_an,
    output logic [7:0]                    sseg_ca
);

    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_W-1:0]     head;
    state_t                state;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [DIG_W-1:0]      digit_idx;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [DATA_W-1:0]     disp_word;
    logic                  blank;
    logic                  lead_blank;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] an_next;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == LOAD);

    wb_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            disp_word <= '0;
            blank     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) state <= LOAD;
                end
                LOAD: begin
                    disp_word <= head;
                    blank     <= 1'b0;
                    hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
                    state     <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= empty ? IDLE : LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign nibble = disp_word[4*digit_idx +: 4];

`ifdef SSEG_BLANK_LEAD_EN
    // Highest nonzero nibble; digit 0 is never blanked, so a zero word still shows "0"
    logic [DIG_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_word[4*i +: 4] != 4'h0) msd = DIG_W'(i);
        end
    end

    assign lead_blank = (digit_idx > msd);
`else
    assign lead_blank = 1'b0;
`endif

    always_comb begin
        an_next            = '1;
        an_next[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_an <= '1;
            sseg_ca <= SEG_BLANK;
        end else begin
            sseg_an <= an_next;
            sseg_ca <= (blank || lead_blank) ? SEG_BLANK : {1'b1, hexseg(nibble)};
        end
    end

endmodule

// File: tb/tb_sseg_writeback_display.sv
// tb/tb_sseg_writeback_display.sv - directed self-checking bench for sseg_writeback_display
module tb_sseg_writeback_display;

    localparam int DATA_W      = 32;
    localparam int NUM_DIGITS  = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int SCAN_DIV    = 4;
    localparam int HOLD_CYCLES = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [2:0]  occupancy;
    logic        overflow;
    logic [7:0]  sseg_an;
    logic [7:0]  sseg_ca;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sseg_writeback_display #(
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (NUM_DIGITS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .occupancy (occupancy),
        .overflow  (overflow),
        .sseg_an   (sseg_an),
        .sseg_ca   (sseg_ca)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Release lands 1 time unit after an edge; the next edge is cycle 1
    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        step();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (sseg_an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", sseg_an); end
        checks++; if (sseg_ca !== 8'hFF) begin errors++; $display("FAIL reset_ca: got %h want ff", sseg_ca); end
        in_valid = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [7:0] exp_an;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_an = 8'hFF ^ (8'h01 << (((k - 1) / 4) % 8));
            checks++; if (sseg_an !== exp_an) begin errors++; $display("FAIL idle_an c%0d: got %h want %h", k, sseg_an, exp_an); end
            checks++; if (sseg_ca !== 8'hFF) begin errors++; $display("FAIL idle_ca c%0d: got %h want ff", k, sseg_ca); end
        end
    endtask

    task automatic test_first_word();
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL fw_occ1: got %0d want 1", occupancy); end
        checks++; if (dut.disp_word !== 32'h0) begin errors++; $display("FAIL fw_disp_e1: got %h want 0", dut.disp_word); end
        step();
        checks++; if (dut.disp_word !== 32'h0) begin errors++; $display("FAIL fw_disp_e2: got %h want 0", dut.disp_word); end
        step();
        checks++; if (dut.disp_word !== 32'h1234_5678) begin errors++; $display("FAIL fw_disp_e3: got %h want 12345678", dut.disp_word); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fw_occ3: got %0d want 0", occupancy); end
        checks++; if (sseg_ca !== 8'hFF) begin errors++; $display("FAIL fw_ca_e3: got %h want ff", sseg_ca); end
        step();
        checks++; if (sseg_an !== 8'hFE) begin errors++; $display("FAIL fw_an_d0: got %h want fe", sseg_an); end
        checks++; if (sseg_ca !== 8'h80) begin errors++; $display("FAIL fw_ca_d0: got %h want 80", sseg_ca); end
        run_to(5);
        checks++; if (sseg_an !== 8'hFD) begin errors++; $display("FAIL fw_an_d1: got %h want fd", sseg_an); end
        checks++; if (sseg_ca !== 8'hF8) begin errors++; $display("FAIL fw_ca_d1: got %h want f8", sseg_ca); end
        run_to(8);
        checks++; if (sseg_an !== 8'hFD) begin errors++; $display("FAIL fw_an_c8: got %h want fd", sseg_an); end
        run_to(9);
        checks++; if (sseg_an !== 8'hFB) begin errors++; $display("FAIL fw_an_d2: got %h want fb", sseg_an); end
        checks++; if (sseg_ca !== 8'h82) begin errors++; $display("FAIL fw_ca_d2: got %h want 82", sseg_ca); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [6];
        int idx;
        w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
        w[3] = 32'h4444_0004; w[4] = 32'h5555_0005; w[5] = 32'h6666_0006;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            step();
            if (i == 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c4: got %b want 1", in_ready); end
                checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL b2b_occ_c4: got %0d want 3", occupancy); end
            end
            if (i == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c5: got %b want 0", in_ready); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL b2b_occ_c5: got %0d want 4", occupancy); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_c5: got %b want 0", overflow); end
            end
            if (i == 5) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_c6: got %b want 1", overflow); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL b2b_occ_c6: got %0d want 4", occupancy); end
            end
        end
        in_valid = 1'b0;
        while (cyc < 70) begin
            step();
            idx = (cyc - 3) / 11;
            if (idx > 4) idx = 4;
            checks++; if (dut.disp_word !== w[idx]) begin errors++; $display("FAIL b2b_disp c%0d: got %h want %h", cyc, dut.disp_word, w[idx]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky: got %b want 1", overflow); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_push_pop();
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'hAAAA_0000;
        step();
        in_data  = 32'hBBBB_1111;
        step();
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL pp_occ_c2: got %0d want 2", occupancy); end
        in_data  = 32'hCCCC_2222;
        step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL pp_occ_c3: got %0d want 2", occupancy); end
        checks++; if (dut.disp_word !== 32'hAAAA_0000) begin errors++; $display("FAIL pp_disp_c3: got %h want aaaa0000", dut.disp_word); end
        run_to(14);
        checks++; if (dut.disp_word !== 32'hBBBB_1111) begin errors++; $display("FAIL pp_disp_c14: got %h want bbbb1111", dut.disp_word); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL pp_occ_c14: got %0d want 1", occupancy); end
        run_to(25);
        checks++; if (dut.disp_word !== 32'hCCCC_2222) begin errors++; $display("FAIL pp_disp_c25: got %h want cccc2222", dut.disp_word); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL pp_occ_c25: got %0d want 0", occupancy); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0BAD_0000 + i;
            step();
        end
        in_valid = 1'b0;
        run_to(16);
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mh_occ_pre: got %0d want 3", occupancy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mh_ovf_pre: got %b want 1", overflow); end
        checks++; if (sseg_an !== 8'hF7) begin errors++; $display("FAIL mh_an_pre: got %h want f7", sseg_an); end
        rst = 1'b1;
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mh_occ_async: got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mh_ready_async: got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mh_ovf_async: got %b want 0", overflow); end
        checks++; if (sseg_an !== 8'hFF) begin errors++; $display("FAIL mh_an_async: got %h want ff", sseg_an); end
        checks++; if (sseg_ca !== 8'hFF) begin errors++; $display("FAIL mh_ca_async: got %h want ff", sseg_ca); end
        in_valid = 1'b1;
        in_data  = 32'h7777_7777;
        step();
        step();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mh_occ_inrst: got %0d want 0", occupancy); end
        in_valid = 1'b0;
        rst = 1'b0;
        cyc = 0;
        step();
        checks++; if (sseg_an !== 8'hFE) begin errors++; $display("FAIL mh_an_restart: got %h want fe", sseg_an); end
        checks++; if (sseg_ca !== 8'hFF) begin errors++; $display("FAIL mh_ca_restart: got %h want ff", sseg_ca); end
        checks++; if (dut.disp_word !== 32'h0) begin errors++; $display("FAIL mh_disp_restart: got %h want 0", dut.disp_word); end
    endtask

    task automatic test_leading();
        logic [7:0] exp_hi;
        logic [7:0] exp_an;
`ifdef SSEG_BLANK_LEAD_EN
        exp_hi = 8'hFF;
`else
        exp_hi = 8'hC0;
`endif
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0000_000A;
        step();
        in_valid = 1'b0;
        run_to(4);
        checks++; if (sseg_an !== 8'hFE) begin errors++; $display("FAIL lead_an_d0: got %h want fe", sseg_an); end
        checks++; if (sseg_ca !== 8'h88) begin errors++; $display("FAIL lead_ca_d0: got %h want 88", sseg_ca); end
        for (int d = 1; d < 8; d++) begin
            run_to(4 * d + 1);
            exp_an = 8'hFF ^ (8'h01 << d);
            checks++; if (sseg_an !== exp_an) begin errors++; $display("FAIL lead_an_d%0d: got %h want %h", d, sseg_an, exp_an); end
            checks++; if (sseg_ca !== exp_hi) begin errors++; $display("FAIL lead_ca_d%0d: got %h want %h", d, sseg_ca, exp_hi); end
        end
        run_to(33);
        checks++; if (sseg_an !== 8'hFE) begin errors++; $display("FAIL lead_an_wrap: got %h want fe", sseg_an); end
        checks++; if (sseg_ca !== 8'h88) begin errors++; $display("FAIL lead_ca_wrap: got %h want 88", sseg_ca); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_first_word();
        test_back_to_back();
        test_push_pop();
        test_reset_mid_hold();
        test_leading();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
